alu_mul_seq: RTL and testbench

Multi-cycle sequencer that computes an unsigned 16x16 -> 32-bit product by driving an external ALU16 instance through shift-add iterations. It owns the ALU operand and opcode lines while busy and exposes a valid/ready handshake on both request and result sides. The block sits beside the ALU in the execute stage and serves multiply instructions without a dedicated multiplier array.

---
 rtl/alu_mul_seq_pkg.sv | 18 +
 rtl/alu16.sv | 39 +++
 rtl/alu_mul_seq_shift_reg.sv | 38 +++
 rtl/alu_mul_seq.sv | 102 ++++++++++
 tb/tb_alu_mul_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the shift-add multiply sequencer and the ALU16 it drives.
package alu_mul_seq_pkg;

  localparam int WIDTH = 16;

  // Op[3] negates B, Op[2:0] selects the function
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu16.sv
// 16-bit ALU shared in the execute stage: AND, OR and add/subtract with optional operand inversion.
module ALU16
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = alu_mul_seq_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             AInvert,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  assign a_eff = AInvert ? ~A : A;
  assign b_eff = Op[3] ? ~B : B;
  assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Op[3]};

  always_comb begin
    Result = '0;
    case (Op[2:0])
      3'b000:  Result = a_eff & b_eff;
      3'b001:  Result = a_eff | b_eff;
      3'b100:  Result = sum[WIDTH-1:0];
      default: Result = '0;
    endcase
  end

  assign CarryOut = sum[WIDTH];
  assign Overflow = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
  assign Zero     = (Result == '0);

endmodule

// File: rtl/alu_mul_seq_shift_reg.sv
// 33-bit {carry, Hi, Lo} accumulator: loads the multiplier into Lo and shifts one partial-sum step per cycle.
module alu_mul_seq_shift_reg
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = alu_mul_seq_pkg::WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_lo,
  input  logic             shift,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             c_sel;
  logic [WIDTH-1:0] s_sel;

  // Lo[0] decides whether this step adds the multiplicand or just shifts
  assign c_sel = lo[0] ? carry : 1'b0;
  assign s_sel = lo[0] ? sum : hi;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hi <= '0;
      lo <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= load_lo;
    end else if (shift) begin
      hi <= {c_sel, s_sel[WIDTH-1:1]};
      lo <= {s_sel[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH multiply by iterating ADDs on the shared ALU16, with valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for a request, InReady high
//   RUN   | one shift-add step per cycle through the ALU
//   DONE  | product held on Product until OutReady
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = alu_mul_seq_pkg::WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   MulA,
  input  logic [WIDTH-1:0]   MulB,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [2*WIDTH-1:0] Product,
  output logic               HiNonZero,
  output logic [WIDTH-1:0]   AluA,
  output logic [WIDTH-1:0]   AluB,
  output logic               AluAInvert,
  output logic [3:0]         AluOp,
  input  logic [WIDTH-1:0]   AluResult,
  input  logic               AluCarryOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             accept;
  logic             run;

  assign accept = (state == IDLE) && InValid;
  assign run    = (state == RUN);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      m     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        m   <= MulA;
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    InReady  = 1'b0;
    OutValid = 1'b0;
    AluA     = '0;
    AluB     = '0;
    AluOp    = OP_AND;
    case (state)
      IDLE: begin
        InReady = !Reset;
        if (InValid) state_nx = RUN;
      end
      RUN: begin
        AluA  = hi;
        AluB  = m;
        AluOp = OP_ADD;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign AluAInvert = 1'b0;
  assign Product    = OutValid ? {hi, lo} : '0;
  assign HiNonZero  = OutValid && (|hi);

  alu_mul_seq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (accept),
    .load_lo (MulB),
    .shift   (run),
    .sum     (AluResult),
    .carry   (AluCarryOut),
    .hi      (hi),
    .lo      (lo)
  );

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq driving a real ALU16: product table plus backpressure, busy and reset sequences.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [15:0] MulA;
  logic [15:0] MulB;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Product;
  logic        HiNonZero;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic        AluAInvert;
  logic [3:0]  AluOp;
  logic [15:0] AluResult;
  logic        AluCarryOut;
  logic        alu_ovf;
  logic        alu_zero;

  int checks = 0;
  int passed = 0;

  alu_mul_seq dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .MulA        (MulA),
    .MulB        (MulB),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Product     (Product),
    .HiNonZero   (HiNonZero),
    .AluA        (AluA),
    .AluB        (AluB),
    .AluAInvert  (AluAInvert),
    .AluOp       (AluOp),
    .AluResult   (AluResult),
    .AluCarryOut (AluCarryOut)
  );

  ALU16 u_alu (
    .A        (AluA),
    .B        (AluB),
    .AInvert  (AluAInvert),
    .Op       (AluOp),
    .Result   (AluResult),
    .CarryOut (AluCarryOut),
    .Overflow (alu_ovf),
    .Zero     (alu_zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    logic        hnz;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issues one request and waits for the result; ok flags any RUN-phase ALU drive or InReady violation.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic ready,
                         input logic hold, output logic [31:0] prod, output logic hnz,
                         output int lat, output logic ok);
    int n;
    n = 0;
    ok = 1'b1;
    MulA = a;
    MulB = b;
    InValid = 1'b1;
    OutReady = ready;
    while (!InReady && n < 50) begin
      tick();
      n++;
    end
    if (!InReady) ok = 1'b0;
    tick();
    if (!hold) InValid = 1'b0;
    lat = 0;
    while (!OutValid && lat < 40) begin
      if (AluOp !== OP_ADD || AluB !== a || AluAInvert !== 1'b0 || InReady !== 1'b0) ok = 1'b0;
      if (hold) begin
        MulA = 16'($urandom);
        MulB = 16'($urandom);
      end
      tick();
      lat++;
    end
    prod = Product;
    hnz = HiNonZero;
    InValid = 1'b0;
    if (ready) tick();
  endtask

  initial begin
    logic [31:0] prod;
    logic        hnz;
    int          lat;
    logic        ok;
    logic        stable;
    logic        seen;

    vecs[0] = '{16'd3,     16'd5,     32'd15,         1'b0};
    vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001,   1'b1};
    vecs[2] = '{16'h0000,  16'h1234,  32'h00000000,   1'b0};
    vecs[3] = '{16'h1234,  16'h0000,  32'h00000000,   1'b0};
    vecs[4] = '{16'h1234,  16'h5678,  32'h06260060,   1'b1};
    vecs[5] = '{16'hFFFF,  16'h0001,  32'h0000FFFF,   1'b0};
    vecs[6] = '{16'h8000,  16'h0002,  32'h00010000,   1'b1};
    vecs[7] = '{16'h00FF,  16'h0101,  32'h0000FFFF,   1'b0};

    Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b0;
    MulA = '0;
    MulB = '0;
    tick();
    tick();
    chk("reset_inready", 32'(InReady), 32'd0);
    chk("reset_outvalid", 32'(OutValid), 32'd0);
    chk("reset_product", Product, 32'd0);
    chk("reset_alu_ab", {AluA, AluB}, 32'd0);
    chk("reset_aluop", 32'(AluOp), 32'd0);
    Reset = 1'b0;
    #1;
    chk("idle_inready", 32'(InReady), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_mul(vecs[i].a, vecs[i].b, 1'b1, 1'b0, prod, hnz, lat, ok);
      chk($sformatf("vec%0d_product", i), prod, vecs[i].prod);
      chk($sformatf("vec%0d_hinonzero", i), 32'(hnz), 32'(vecs[i].hnz));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
      chk($sformatf("vec%0d_run_drive", i), 32'(ok), 32'd1);
    end
    chk("idle_alu_zero", {AluA, AluB}, 32'd0);
    chk("idle_aluop_zero", 32'(AluOp), 32'd0);

    // backpressure: result must hold for as long as OutReady stays low
    run_mul(16'h0100, 16'h0100, 1'b0, 1'b0, prod, hnz, lat, ok);
    chk("bp_product", prod, 32'h00010000);
    chk("bp_latency", 32'(lat), 32'd16);
    stable = 1'b1;
    repeat (10) begin
      if (OutValid !== 1'b1 || Product !== 32'h00010000 || InReady !== 1'b0 || HiNonZero !== 1'b1)
        stable = 1'b0;
      tick();
    end
    chk("bp_hold", 32'(stable), 32'd1);
    OutReady = 1'b1;
    tick();
    chk("bp_release_outvalid", 32'(OutValid), 32'd0);
    chk("bp_release_inready", 32'(InReady), 32'd1);

    // busy: InValid stays high with changing operands during RUN
    run_mul(16'd3, 16'd5, 1'b0, 1'b1, prod, hnz, lat, ok);
    chk("busy_product", prod, 32'd15);
    chk("busy_no_accept", 32'(ok), 32'd1);
    chk("busy_latency", 32'(lat), 32'd16);
    OutReady = 1'b1;
    tick();
    chk("busy_handshake_inready", 32'(InReady), 32'd1);

    // reset after the 7th RUN cycle discards the partial product
    MulA = 16'd2;
    MulB = 16'd3;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    repeat (7) tick();
    chk("mid_run_aluop", 32'(AluOp), 32'(OP_ADD));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    chk("midrst_outvalid", 32'(OutValid), 32'd0);
    chk("midrst_product", Product, 32'd0);
    chk("midrst_aluop", 32'(AluOp), 32'd0);
    chk("midrst_inready", 32'(InReady), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      if (OutValid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    run_mul(16'd7, 16'd9, 1'b1, 1'b0, prod, hnz, lat, ok);
    chk("after_rst_product", prod, 32'd63);
    chk("after_rst_latency", 32'(lat), 32'd16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
